xbar_packet_arbiter: RTL and testbench

XBAR_PACKET_ARBITER -- requirements
Module: xbar_packet_arbiter

---
 rtl/xbar_packet_arbiter.sv | 69 ++++++
 tb/tb_xbar_packet_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/xbar_packet_arbiter.sv
// xbar_packet_arbiter: per-slave packet-locked arbitration of stream masters onto stream slaves.
module xbar_packet_arbiter #(
  parameter int S_DATA_COUNT = 4,
  parameter int M_DATA_COUNT = 3,
  parameter int ARB_MODE = 0,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_in,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
  input  logic [S_DATA_COUNT-1:0]                    s_last_i,
  output logic [S_DATA_COUNT-1:0]                    s_ready_o,
  input  logic [M_DATA_COUNT-1:0]                    m_ready_i,
  output logic [M_DATA_COUNT-1:0]                    m_valid_o,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  grant_o,
  output logic [M_DATA_COUNT-1:0]                    grant_valid_o
);
  typedef enum logic {IDLE, LOCKED} state_t;
  function automatic logic [T_ID___WIDTH-1:0] pick(input logic [S_DATA_COUNT-1:0] r, input logic [T_ID___WIDTH-1:0] p);
    logic [T_ID___WIDTH-1:0] w;
    int idx;
    w = '0;
    for (int k = S_DATA_COUNT - 1; k >= 0; k--) begin
      idx = ARB_MODE == 0 ? int'(p) + k : k;
      idx = idx >= S_DATA_COUNT ? idx - S_DATA_COUNT : idx;
      if (r[idx]) w = T_ID___WIDTH'(idx);
    end
    return w;
  endfunction
  logic [S_DATA_COUNT-1:0] rdy [M_DATA_COUNT];
  for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_slv
    state_t state;
    logic [T_ID___WIDTH-1:0] ptr, g;
    logic [S_DATA_COUNT-1:0] req;
    logic locked, dest_ok;
    always_comb begin
      req = '0;
      for (int j = 0; j < S_DATA_COUNT; j++) req[j] = s_valid_i[j] && (s_dest_i[j] == T_DEST_WIDTH'(i));
    end
    assign locked = state == LOCKED;
    assign dest_ok = s_dest_i[g] == T_DEST_WIDTH'(i);
    assign m_valid_o[i] = locked && s_valid_i[g] && dest_ok;
    assign rdy[i] = locked && m_ready_i[i] && dest_ok ? S_DATA_COUNT'(1) << g : '0;
    assign grant_o[i] = g;
    assign grant_valid_o[i] = locked;
    always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
        state <= IDLE;
        ptr <= '0;
        g <= '0;
      end else if (!locked) begin
        if (|req) begin
          g <= pick(req, ptr);
          state <= LOCKED;
        end
      end else if (m_valid_o[i] && m_ready_i[i] && s_last_i[g]) begin
        state <= IDLE;
        if (ARB_MODE == 0) ptr <= g == T_ID___WIDTH'(S_DATA_COUNT - 1) ? '0 : g + 1'b1;
      end
    end
  end
  // a master normally locks at most one slave; OR keeps it defined if dest moves mid-packet
  always_comb begin
    s_ready_o = '0;
    for (int i = 0; i < M_DATA_COUNT; i++) s_ready_o |= rdy[i];
  end
endmodule

// File: tb/tb_xbar_packet_arbiter.sv
// tb_xbar_packet_arbiter: directed checks of round-robin and fixed-priority instances side by side.
module tb_xbar_packet_arbiter;
  logic clk_i = 1'b0;
  logic rst_in;
  logic [3:0][1:0] s_dest_i;
  logic [3:0] s_valid_i, s_last_i, s_ready_rr, s_ready_fp;
  logic [2:0] m_ready_i, m_valid_rr, m_valid_fp, gv_rr, gv_fp;
  logic [2:0][1:0] grant_rr, grant_fp;
  int n_pass = 0;
  int n_total = 0;
  always #5 clk_i = ~clk_i;
  xbar_packet_arbiter #(.S_DATA_COUNT(4), .M_DATA_COUNT(3), .ARB_MODE(0)) dut_rr (
    .clk_i(clk_i), .rst_in(rst_in), .s_dest_i(s_dest_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
    .s_ready_o(s_ready_rr), .m_ready_i(m_ready_i), .m_valid_o(m_valid_rr), .grant_o(grant_rr), .grant_valid_o(gv_rr));
  xbar_packet_arbiter #(.S_DATA_COUNT(4), .M_DATA_COUNT(3), .ARB_MODE(1)) dut_fp (
    .clk_i(clk_i), .rst_in(rst_in), .s_dest_i(s_dest_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
    .s_ready_o(s_ready_fp), .m_ready_i(m_ready_i), .m_valid_o(m_valid_fp), .grant_o(grant_fp), .grant_valid_o(gv_fp));

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear;
    s_valid_i = '0;
    s_last_i = '0;
    s_dest_i = '0;
    m_ready_i = '0;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    clear();
    #2;
    n_total++; if (gv_rr !== 3'b000) $display("FAIL reset_gv got %b want 000", gv_rr); else n_pass++;
    n_total++; if (grant_rr !== 6'd0) $display("FAIL reset_grant got %h want 0", grant_rr); else n_pass++;
    s_valid_i = 4'b0001;
    m_ready_i = 3'b111;
    tick();
    tick();
    n_total++; if (gv_rr !== 3'b000 || gv_fp !== 3'b000) $display("FAIL reset_held_gv got %b/%b want 000", gv_rr, gv_fp); else n_pass++;
    n_total++; if (m_valid_rr !== 3'b000) $display("FAIL reset_m_valid got %b want 000", m_valid_rr); else n_pass++;
    n_total++; if (s_ready_rr !== 4'b0000) $display("FAIL reset_s_ready got %b want 0000", s_ready_rr); else n_pass++;
    clear();
    rst_in = 1'b1;
  endtask

  task automatic test_alternation;
    s_dest_i[0] = 2'd1;
    s_dest_i[2] = 2'd1;
    s_valid_i = 4'b0101;
    s_last_i = 4'b0101;
    m_ready_i = 3'b010;
    #1;
    n_total++; if (gv_rr !== 3'b000) $display("FAIL alt_pre_gv got %b want 000", gv_rr); else n_pass++;
    tick();
    n_total++; if (gv_rr[1] !== 1'b1 || grant_rr[1] !== 2'd0) $display("FAIL alt_rr_first gv %b grant %0d want 1/0", gv_rr[1], grant_rr[1]); else n_pass++;
    n_total++; if (s_ready_rr !== 4'b0001) $display("FAIL alt_rr_ready1 got %b want 0001", s_ready_rr); else n_pass++;
    n_total++; if (m_valid_rr !== 3'b010) $display("FAIL alt_rr_mvalid got %b want 010", m_valid_rr); else n_pass++;
    n_total++; if (grant_fp[1] !== 2'd0 || s_ready_fp !== 4'b0001) $display("FAIL alt_fp_first grant %0d ready %b want 0/0001", grant_fp[1], s_ready_fp); else n_pass++;
    tick();
    n_total++; if (gv_rr[1] !== 1'b0 || gv_fp[1] !== 1'b0) $display("FAIL alt_bubble1 got %b/%b want 0/0", gv_rr[1], gv_fp[1]); else n_pass++;
    n_total++; if (s_ready_rr !== 4'b0000 || m_valid_rr !== 3'b000) $display("FAIL alt_bubble_out ready %b mvalid %b want 0", s_ready_rr, m_valid_rr); else n_pass++;
    tick();
    n_total++; if (gv_rr[1] !== 1'b1 || grant_rr[1] !== 2'd2) $display("FAIL alt_rr_second gv %b grant %0d want 1/2", gv_rr[1], grant_rr[1]); else n_pass++;
    n_total++; if (s_ready_rr !== 4'b0100) $display("FAIL alt_rr_ready2 got %b want 0100", s_ready_rr); else n_pass++;
    n_total++; if (grant_fp[1] !== 2'd0 || s_ready_fp !== 4'b0001) $display("FAIL alt_fp_second grant %0d ready %b want 0/0001", grant_fp[1], s_ready_fp); else n_pass++;
    tick();
    n_total++; if (gv_rr[1] !== 1'b0) $display("FAIL alt_bubble2 got %b want 0", gv_rr[1]); else n_pass++;
    tick();
    n_total++; if (grant_rr[1] !== 2'd0 || gv_rr[1] !== 1'b1) $display("FAIL alt_rr_third grant %0d gv %b want 0/1", grant_rr[1], gv_rr[1]); else n_pass++;
    n_total++; if (grant_fp[1] !== 2'd0 || s_ready_fp[2] !== 1'b0) $display("FAIL alt_fp_starve grant %0d ready2 %b want 0/0", grant_fp[1], s_ready_fp[2]); else n_pass++;
    s_valid_i = 4'b0001;
    tick();
    clear();
  endtask

  task automatic test_hold;
    int beats = 0;
    s_dest_i[1] = 2'd2;
    s_dest_i[3] = 2'd2;
    s_valid_i = 4'b1010;
    s_last_i = 4'b1000;
    tick();
    n_total++; if (gv_rr[2] !== 1'b1 || grant_rr[2] !== 2'd1) $display("FAIL hold_grant gv %b grant %0d want 1/1", gv_rr[2], grant_rr[2]); else n_pass++;
    for (int c = 0; c < 8; c++) begin
      m_ready_i[2] = c[0];
      s_valid_i[1] = c != 2;
      s_last_i[1] = beats == 3;
      #1;
      n_total++; if (gv_rr[2] !== 1'b1 || grant_rr[2] !== 2'd1) $display("FAIL hold_locked c=%0d gv %b grant %0d want 1/1", c, gv_rr[2], grant_rr[2]); else n_pass++;
      n_total++; if (m_valid_rr[2] !== (c != 2) || s_ready_rr !== {2'b00, c[0], 1'b0}) $display("FAIL hold_hs c=%0d mvalid %b ready %b", c, m_valid_rr[2], s_ready_rr); else n_pass++;
      if (c[0] && c != 2) beats++;
      tick();
    end
    s_valid_i[1] = 1'b0;
    s_last_i[1] = 1'b0;
    m_ready_i[2] = 1'b1;
    #1;
    n_total++; if (gv_rr[2] !== 1'b0 || s_ready_rr[3] !== 1'b0) $display("FAIL hold_bubble gv %b ready3 %b want 0/0", gv_rr[2], s_ready_rr[3]); else n_pass++;
    tick();
    n_total++; if (gv_rr[2] !== 1'b1 || grant_rr[2] !== 2'd3) $display("FAIL hold_next gv %b grant %0d want 1/3", gv_rr[2], grant_rr[2]); else n_pass++;
    n_total++; if (grant_fp[2] !== 2'd3 || s_ready_rr !== 4'b1000) $display("FAIL hold_next_fp grant %0d ready %b want 3/1000", grant_fp[2], s_ready_rr); else n_pass++;
    tick();
    clear();
  endtask

  task automatic test_concurrent;
    s_dest_i = {2'd2, 2'd0, 2'd1, 2'd0};
    s_valid_i = 4'b1011;
    m_ready_i = 3'b111;
    #1;
    n_total++; if (gv_rr !== 3'b000) $display("FAIL conc_pre got %b want 000", gv_rr); else n_pass++;
    tick();
    n_total++; if (gv_rr !== 3'b111) $display("FAIL conc_gv got %b want 111", gv_rr); else n_pass++;
    n_total++; if (grant_rr !== {2'd3, 2'd1, 2'd0}) $display("FAIL conc_grant got %h want 34", grant_rr); else n_pass++;
    n_total++; if (m_valid_rr !== 3'b111 || s_ready_rr !== 4'b1011) $display("FAIL conc_xfer mvalid %b ready %b want 111/1011", m_valid_rr, s_ready_rr); else n_pass++;
    s_last_i = 4'b1011;
    tick();
    n_total++; if (gv_rr !== 3'b000) $display("FAIL conc_release got %b want 000", gv_rr); else n_pass++;
    clear();
  endtask

  task automatic test_bad_dest;
    s_dest_i[2] = 2'd3;
    s_valid_i = 4'b0100;
    s_last_i = 4'b0100;
    m_ready_i = 3'b111;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++; if (gv_rr !== 3'b000 || s_ready_rr[2] !== 1'b0 || m_valid_rr !== 3'b000) $display("FAIL bad_dest c=%0d gv %b ready %b mvalid %b want 0", c, gv_rr, s_ready_rr, m_valid_rr); else n_pass++;
    end
    clear();
  endtask

  task automatic test_async_reset;
    s_dest_i[0] = 2'd1;
    s_dest_i[3] = 2'd1;
    s_valid_i = 4'b1001;
    m_ready_i = 3'b010;
    tick();
    n_total++; if (grant_rr[1] !== 2'd3 || gv_rr[1] !== 1'b1) $display("FAIL ar_pre grant %0d gv %b want 3/1", grant_rr[1], gv_rr[1]); else n_pass++;
    #2 rst_in = 1'b0;
    #1;
    n_total++; if (gv_rr !== 3'b000 || grant_rr !== 6'd0) $display("FAIL ar_async gv %b grant %h want 0", gv_rr, grant_rr); else n_pass++;
    n_total++; if (m_valid_rr !== 3'b000 || s_ready_rr !== 4'b0000) $display("FAIL ar_async_out mvalid %b ready %b want 0", m_valid_rr, s_ready_rr); else n_pass++;
    #2 rst_in = 1'b1;
    tick();
    n_total++; if (grant_rr[1] !== 2'd0 || gv_rr[1] !== 1'b1) $display("FAIL ar_after grant %0d gv %b want 0/1", grant_rr[1], gv_rr[1]); else n_pass++;
    s_last_i = 4'b1001;
    tick();
    clear();
  endtask

  initial begin
    test_reset();
    tick();
    test_alternation();
    test_hold();
    test_concurrent();
    test_bad_dest();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
